booth_pp_generator: RTL and testbench
=====================================

Name: booth_pp_generator

Overview:
- Radix-4 Booth partial-product generator; the stage directly upstream of partial_product_adder.
- Latches a signed multiplicand/multiplier pair on start.
- Emits one sign-extended, pre-shifted partial product per cycle with a valid strobe; the downstream adder sums them into the product.
- The downstream adder is instantiated with its DATA_WIDTH equal to this block's 2*DATA_WIDTH.

Parameters:
- DATA_WIDTH, 16, operand width in bits. Must be even and at least 4.
- PP_COUNT, DATA_WIDTH/2, number of Booth digits. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a multiplication; sampled only in IDLE.
- multiplicand  input  DATA_WIDTH  signed operand A; latched on an accepted start.
- multiplier  input  DATA_WIDTH  signed operand B; latched on an accepted start.
- pp_hold  input  1  stall request from downstream; pauses emission.
- busy  output  1  high while an operation is in progress.
- partial_product  output  2*DATA_WIDTH  shifted, sign-extended partial product.
- partial_product_valid  output  1  partial_product is valid this cycle.
- pp_index  output  $clog2(PP_COUNT)  Booth digit index of the current partial product.
- pp_last  output  1  marks the final partial product of the operation.
- done  output  1  one-cycle pulse after the final partial product.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - busy, partial_product_valid, pp_last and done go to 0.
  - partial_product, pp_index and the latched operands go to 0.
- FSM states: IDLE, GEN, DONE.
- IDLE:
  - On start=1, latch both operands, clear the digit counter, go to GEN.
  - busy rises on the next edge.
- start is ignored in GEN and DONE. No queueing.
- GEN, per cycle with pp_hold=0:
  - Digit i is taken from multiplier bits {2i+1, 2i, 2i-1}, with bit -1 = 0.
  - d = -2*b[2i+1] + b[2i] + b[2i-1], so d is in {-2, -1, 0, +1, +2}.
  - Register partial_product = (sign-extend(A) * d) << 2i, computed and truncated to 2*DATA_WIDTH bits.
  - The multiply by d is a select/negate/shift only; no multiplier is inferred.
  - partial_product_valid=1, pp_index=i; increment i.
- GEN with pp_hold=1:
  - partial_product_valid=0; counter and operands hold.
  - partial_product and pp_index hold their last values.
- Registered outputs: partial_product is 0 whenever partial_product_valid=0, except while holding under pp_hold.
- End of GEN: on emission of i=PP_COUNT-1, assert pp_last=1 with that valid, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, partial_product_valid=0, busy=1.
  - Next state is IDLE; busy falls on that edge.
- Latency without holds:
  - First valid is 1 cycle after the start edge.
  - Last valid is PP_COUNT cycles after the start edge.
  - done is PP_COUNT+1 cycles after the start edge.
  - A new start is accepted the cycle after done.
- Arithmetic invariant: the sum of all emitted partial_products, mod 2^(2*DATA_WIDTH), equals the signed product A*B. This holds including A=B=most-negative (0x8000*0x8000 = 0x40000000).
- Simultaneous start and pp_hold in IDLE: start is accepted; the hold applies from the first GEN cycle.

Optional Feature:
- Macro: BOOTH_SKIP_ZERO_EN.
- Defined:
  - On accepted start, compute a PP_COUNT-bit nonzero-digit mask.
  - Digits with d=0 are skipped with no cycle spent.
  - pp_index reports the true digit index.
  - pp_last marks the highest nonzero digit.
  - If all digits are zero (B=0), GEN is bypassed: go directly to DONE, no valid is emitted, and done fires 1 cycle after start.
- Undefined: every digit is emitted, including zero partial products (partial_product=0, valid=1).

Test Plan:
1. A=0x0003, B=0x0005 (no macro) -> 8 valids on consecutive cycles.
   - pp0=0x00000003, pp1=0x0000000C, pp2..pp7=0.
   - pp_last with index 7; done the next cycle; sum 0x0000000F.
2. A=0xFC00, B=0x0002 -> pp0=0x00000800, pp1=0xFFFFF000, rest 0; sum 0xFFFFF800 (-2048).
3. A=0x8000, B=0x8000 -> only pp7 nonzero, equal to 0x40000000; sum 0x40000000.
4. A=0x1234, B=0x5678 with pp_hold high for 3 cycles after the 2nd valid:
   - No valids during the hold; index resumes at 2.
   - done is 3 cycles later than nominal; sum 0x06260060.
   - A start pulse mid-operation is ignored.
5. Assert reset 3 cycles into GEN:
   - All outputs go to 0 immediately (asynchronously).
   - After release, a fresh start of A=0x0003, B=0x0005 completes correctly.
6. With BOOTH_SKIP_ZERO_EN, A=0x0003, B=0x0005:
   - Exactly 2 valids (index 0 then 1, pp_last on index 1), then done.
   - With B=0: zero valids, done 1 cycle after start.

Source files
------------

// File: rtl/booth_pp_generator.sv
// Radix-4 Booth partial-product generator feeding partial_product_adder.
// Optional BOOTH_SKIP_ZERO_EN: skip zero Booth digits without spending cycles.
module booth_pp_generator #(
  parameter int DATA_WIDTH = 16,
  parameter int PP_COUNT   = DATA_WIDTH / 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         multiplicand,
  input  logic [DATA_WIDTH-1:0]         multiplier,
  input  logic                          pp_hold,
  output logic                          busy,
  output logic [2*DATA_WIDTH-1:0]       partial_product,
  output logic                          partial_product_valid,
  output logic [$clog2(PP_COUNT)-1:0]   pp_index,
  output logic                          pp_last,
  output logic                          done
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(PP_COUNT);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]   pp_q, pp_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cur;
  logic            is_last;

  // Digit i looks at {b[2i+1], b[2i], b[2i-1]}; b_ext carries the implicit b[-1]=0.
  function automatic logic [2:0] booth_trip(input logic [DW:0] b_ext, input logic [CW-1:0] i);
    logic [CW:0] sh;
    sh = {i, 1'b0};
    return 3'(b_ext >> sh);
  endfunction

  function automatic logic [PW-1:0] booth_pp(input logic [DW-1:0] a, input logic [DW:0] b_ext,
                                             input logic [CW-1:0] i);
    logic [PW-1:0] a_ext;
    logic [PW-1:0] mag;
    logic [CW:0]   sh;
    sh    = {i, 1'b0};
    a_ext = {{DW{a[DW-1]}}, a};
    case (booth_trip(b_ext, i))
      3'b001, 3'b010: mag = a_ext;
      3'b011:         mag = a_ext << 1;
      3'b100:         mag = -(a_ext << 1);
      3'b101, 3'b110: mag = -a_ext;
      default:        mag = '0;
    endcase
    return mag << sh;
  endfunction

`ifdef BOOTH_SKIP_ZERO_EN
  logic [PP_COUNT-1:0] mask_q, mask_d, start_mask, cur_onehot;
  logic                found;

  always_comb begin
    start_mask = '0;
    for (int unsigned i = 0; i < PP_COUNT; i++) begin
      start_mask[i] = (booth_trip({multiplier, 1'b0}, CW'(i)) != 3'b000) &&
                      (booth_trip({multiplier, 1'b0}, CW'(i)) != 3'b111);
    end
    cur   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PP_COUNT; i++) begin
      if (mask_q[i] && !found) begin
        cur   = CW'(i);
        found = 1'b1;
      end
    end
    cur_onehot = PP_COUNT'(1) << cur;
    is_last    = (mask_q & ~cur_onehot) == '0;
  end
`else
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cur     = cnt_q;
    is_last = (cnt_q == CW'(PP_COUNT - 1));
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pp_d    = '0;
    valid_d = 1'b0;
    idx_d   = idx_q;
    last_d  = 1'b0;
    done_d  = 1'b0;
`ifdef BOOTH_SKIP_ZERO_EN
    mask_d  = mask_q;
`else
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          state_d = GEN;
`ifdef BOOTH_SKIP_ZERO_EN
          mask_d  = start_mask;
          if (start_mask == '0) state_d = DONE;
`else
          cnt_d   = '0;
`endif
        end
      end
      GEN: begin
        if (pp_hold) begin
          pp_d = pp_q;
        end else begin
          pp_d    = booth_pp(a_q, {b_q, 1'b0}, cur);
          valid_d = 1'b1;
          idx_d   = cur;
`ifdef BOOTH_SKIP_ZERO_EN
          mask_d  = mask_q & ~cur_onehot;
`else
          cnt_d   = cnt_q + 1'b1;
`endif
          if (is_last) begin
            last_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      pp_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BOOTH_SKIP_ZERO_EN
      mask_q  <= '0;
`else
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pp_q    <= pp_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef BOOTH_SKIP_ZERO_EN
      mask_q  <= mask_d;
`else
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy                  = busy_q;
  assign partial_product       = pp_q;
  assign partial_product_valid = valid_q;
  assign pp_index              = idx_q;
  assign pp_last               = last_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_booth_pp_generator.sv
// Directed bench for booth_pp_generator (DATA_WIDTH=16); expectations follow BOOTH_SKIP_ZERO_EN.
module tb_booth_pp_generator;

  localparam int MAXT = 48;

  logic        clk = 1'b0;
  logic        reset, start, pp_hold;
  logic [15:0] multiplicand, multiplier;
  logic        busy;
  logic [31:0] partial_product;
  logic        partial_product_valid;
  logic [2:0]  pp_index;
  logic        pp_last, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] s_pp    [MAXT];
  logic        s_valid [MAXT];
  logic        s_busy  [MAXT];
  logic [2:0]  s_idx   [MAXT];
  logic [31:0] v_pp    [16];
  logic [2:0]  v_idx   [16];
  logic        v_last  [16];
  int          v_t     [16];
  int          done_t, nvalid;
  logic [31:0] sum;

  always #5 clk = ~clk;

  booth_pp_generator #(.DATA_WIDTH(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .multiplicand          (multiplicand),
    .multiplier            (multiplier),
    .pp_hold               (pp_hold),
    .busy                  (busy),
    .partial_product       (partial_product),
    .partial_product_valid (partial_product_valid),
    .pp_index              (pp_index),
    .pp_last               (pp_last),
    .done                  (done)
  );

  // Called at a negedge; records one sample per cycle until done or the cycle budget runs out.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold_at,
                        input int hold_len, input bit mid_start);
    int hold_rem;
    hold_rem     = 0;
    multiplicand = a;
    multiplier   = b;
    pp_hold      = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    done_t = -1;
    nvalid = 0;
    sum    = '0;
    s_pp[0] = partial_product; s_valid[0] = partial_product_valid;
    s_busy[0] = busy; s_idx[0] = pp_index;
    for (int t = 1; t < MAXT && done_t < 0; t++) begin
      pp_hold = (hold_rem > 0);
      if (hold_rem > 0) hold_rem--;
      if (mid_start && t == 4) begin
        start = 1'b1; multiplicand = 16'hFFFF; multiplier = 16'h7FFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      s_pp[t] = partial_product; s_valid[t] = partial_product_valid;
      s_busy[t] = busy; s_idx[t] = pp_index;
      if (partial_product_valid) begin
        if (nvalid < 16) begin
          v_pp[nvalid] = partial_product; v_idx[nvalid] = pp_index;
          v_last[nvalid] = pp_last; v_t[nvalid] = t;
        end
        nvalid++;
        sum = sum + partial_product;
        if (nvalid == hold_at) hold_rem = hold_len;
      end
      if (done) done_t = t;
    end
    start   = 1'b0;
    pp_hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pp_hold = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    n_checks++;
    if ({busy, partial_product_valid, pp_last, done, pp_index, partial_product} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b valid=%b last=%b done=%b idx=%0d pp=%h, expected all 0",
                         busy, partial_product_valid, pp_last, done, pp_index, partial_product);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({busy, partial_product_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b, expected 0 0 0",
                         busy, partial_product_valid, done);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] ep [3][8];
    logic [31:0] es [3];
    logic [31:0] e_pp [8];
    int          e_idx [8];
    int          n_exp;
    ta[0] = 16'h0003; tb[0] = 16'h0005; es[0] = 32'h0000000F;
    ep[0] = '{32'h3, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ta[1] = 16'hFC00; tb[1] = 16'h0002; es[1] = 32'hFFFFF800;
    ep[1] = '{32'h800, 32'hFFFFF000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ta[2] = 16'h8000; tb[2] = 16'h8000; es[2] = 32'h40000000;
    ep[2] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40000000};
    for (int v = 0; v < 3; v++) begin
      n_exp = 0;
      for (int i = 0; i < 8; i++) begin
`ifdef BOOTH_SKIP_ZERO_EN
        if (ep[v][i] != 32'h0) begin
          e_pp[n_exp] = ep[v][i]; e_idx[n_exp] = i; n_exp++;
        end
`else
        e_pp[n_exp] = ep[v][i]; e_idx[n_exp] = i; n_exp++;
`endif
      end
      run_op(ta[v], tb[v], 0, 0, 1'b0);
      n_checks++;
      if (s_busy[0] !== 1'b1) begin
        n_fail++; $display("FAIL v%0d_busy_rise: got %b expected 1", v, s_busy[0]);
      end
      n_checks++;
      if (nvalid !== n_exp) begin
        n_fail++; $display("FAIL v%0d_valid_count: got %0d expected %0d", v, nvalid, n_exp);
      end
      for (int k = 0; k < n_exp; k++) begin
        if (k < nvalid) begin
          n_checks++;
          if (v_pp[k] !== e_pp[k] || v_idx[k] !== 3'(e_idx[k]) || v_t[k] !== k + 1 ||
              v_last[k] !== (k == n_exp - 1)) begin
            n_fail++; $display("FAIL v%0d_pp%0d: got pp=%h idx=%0d t=%0d last=%b expected pp=%h idx=%0d t=%0d last=%b",
                               v, k, v_pp[k], v_idx[k], v_t[k], v_last[k], e_pp[k], e_idx[k], k + 1, (k == n_exp - 1));
          end
        end
      end
      n_checks++;
      if (done_t !== n_exp + 1) begin
        n_fail++; $display("FAIL v%0d_done_cycle: got %0d expected %0d", v, done_t, n_exp + 1);
      end
      n_checks++;
      if (sum !== es[v]) begin
        n_fail++; $display("FAIL v%0d_sum: got %h expected %h", v, sum, es[v]);
      end
      if (done_t > 0) begin
        n_checks++;
        if (s_busy[done_t] !== 1'b0 || s_busy[done_t - 1] !== 1'b1 || s_pp[done_t] !== 32'h0) begin
          n_fail++; $display("FAIL v%0d_done_state: got busy_at_done=%b busy_before=%b pp=%h expected 0 1 0",
                             v, s_busy[done_t], s_busy[done_t - 1], s_pp[done_t]);
        end
      end
    end
  endtask

  task automatic test_hold();
`ifdef BOOTH_SKIP_ZERO_EN
    int          n_exp = 6;
    logic [2:0]  held_idx = 3'd3, resume_idx = 3'd4;
    logic [31:0] held_pp = 32'h00091A00;
`else
    int          n_exp = 8;
    logic [2:0]  held_idx = 3'd1, resume_idx = 3'd2;
    logic [31:0] held_pp = 32'hFFFF6E60;
`endif
    run_op(16'h1234, 16'h5678, 2, 3, 1'b1);
    n_checks++;
    if (nvalid !== n_exp) begin
      n_fail++; $display("FAIL hold_valid_count: got %0d expected %0d", nvalid, n_exp);
    end
    for (int t = 3; t <= 5; t++) begin
      n_checks++;
      if (s_valid[t] !== 1'b0 || s_pp[t] !== held_pp || s_idx[t] !== held_idx) begin
        n_fail++; $display("FAIL hold_cycle%0d: got valid=%b pp=%h idx=%0d expected 0 %h %0d",
                           t, s_valid[t], s_pp[t], s_idx[t], held_pp, held_idx);
      end
    end
    if (nvalid > 2) begin
      n_checks++;
      if (v_idx[2] !== resume_idx || v_t[2] !== 6) begin
        n_fail++; $display("FAIL hold_resume: got idx=%0d t=%0d expected idx=%0d t=6", v_idx[2], v_t[2], resume_idx);
      end
    end
    n_checks++;
    if (done_t !== n_exp + 4) begin
      n_fail++; $display("FAIL hold_done_cycle: got %0d expected %0d", done_t, n_exp + 4);
    end
    n_checks++;
    if (sum !== 32'h06260060) begin
      n_fail++; $display("FAIL hold_sum: got %h expected 06260060", sum);
    end
  endtask

  task automatic test_async_reset();
    multiplicand = 16'h0003; multiplier = 16'h0005; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, partial_product_valid, pp_last, done, pp_index, partial_product} !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy=%b valid=%b last=%b done=%b idx=%0d pp=%h expected all 0",
                         busy, partial_product_valid, pp_last, done, pp_index, partial_product);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_op(16'h0003, 16'h0005, 0, 0, 1'b0);
    n_checks++;
    if (sum !== 32'h0000000F) begin
      n_fail++; $display("FAIL post_reset_sum: got %h expected 0000000F", sum);
    end
    n_checks++;
`ifdef BOOTH_SKIP_ZERO_EN
    if (done_t !== 3 || nvalid !== 2) begin
      n_fail++; $display("FAIL post_reset_timing: got done=%0d valids=%0d expected 3 2", done_t, nvalid);
    end
`else
    if (done_t !== 9 || nvalid !== 8) begin
      n_fail++; $display("FAIL post_reset_timing: got done=%0d valids=%0d expected 9 8", done_t, nvalid);
    end
`endif
  endtask

  task automatic test_back_to_back();
    run_op(16'hFC00, 16'h0002, 0, 0, 1'b0);
    n_checks++;
    if (sum !== 32'hFFFFF800) begin
      n_fail++; $display("FAIL b2b_first_sum: got %h expected FFFFF800", sum);
    end
    run_op(16'h8000, 16'h8000, 0, 0, 1'b0);
    n_checks++;
    if (s_busy[0] !== 1'b1 || sum !== 32'h40000000) begin
      n_fail++; $display("FAIL b2b_second: got busy=%b sum=%h expected 1 40000000", s_busy[0], sum);
    end
  endtask

  task automatic test_zero_multiplier();
    run_op(16'h1234, 16'h0000, 0, 0, 1'b0);
    n_checks++;
    if (sum !== 32'h0) begin
      n_fail++; $display("FAIL zero_sum: got %h expected 0", sum);
    end
    n_checks++;
`ifdef BOOTH_SKIP_ZERO_EN
    if (nvalid !== 0 || done_t !== 1) begin
      n_fail++; $display("FAIL zero_skip: got valids=%0d done=%0d expected 0 1", nvalid, done_t);
    end
`else
    if (nvalid !== 8 || done_t !== 9) begin
      n_fail++; $display("FAIL zero_noskip: got valids=%0d done=%0d expected 8 9", nvalid, done_t);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_zero_multiplier();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
